m_spi_control: RTL and testbench



---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_clk_div.sv | 42 ++++
 rtl/m_spi_control.sv | 160 ++++++++++++++++
 tb/tb_m_spi_control.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave pair.
//   SPI_DATA_LENGTH : default bits per transfer, also used by the slave block
//   spi_state_e     : master FSM state encoding
//   clog2()         : ceiling log2, usable in constant expressions
package spi_pkg;

    localparam int unsigned SPI_DATA_LENGTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer for the SPI master.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   en        : counts while high; clearing it restarts the timer with a rise next
//   rise_tick : one-cycle strobe, the next registered SCLK edge is a rise
//   fall_tick : one-cycle strobe, the next registered SCLK edge is a fall
// Strobes come every CLK_DIV enabled cycles, alternating rise/fall.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned CNT_W = clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             phase;  // 0: next strobe is a rise
    logic             tick;

    assign tick      = en && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_tick = tick && !phase;
    assign fall_tick = tick && phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/m_spi_control.sv
// SPI master controller, mode 0, MSB first, one SS-framed transfer per request.
//   clk             : system clock, all logic on its rising edge
//   rst             : synchronous active-high reset, aborts any transfer
//   start           : transfer request, sampled only while busy=0
//   data_to_slave   : byte to send, latched when start is accepted
//   data_from_slave : last received byte, updated with done
//   busy            : high from the cycle after acceptance until the gap ends
//   done            : one-cycle pulse at the end of a transfer
//   SCLK            : SPI clock, idles low
//   MOSI            : serial data out
//   MISO            : serial data in, sampled on the SCLK rising-edge cycle
//   SS              : active-low slave select, idles high
module m_spi_control
    import spi_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = SPI_DATA_LENGTH,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] data_to_slave,
    output logic [DATA_LENGTH-1:0] data_from_slave,
    output logic                   busy,
    output logic                   done,
    output logic                   SCLK,
    output logic                   MOSI,
    input  logic                   MISO,
    output logic                   SS
);

    localparam int unsigned BIT_W = clog2(DATA_LENGTH) + 1;
    localparam int unsigned GAP_W = clog2(GAP_CYCLES) + 1;

    spi_state_e             state, state_n;
    logic [DATA_LENGTH-1:0] tx_sr, tx_sr_n;
    logic [DATA_LENGTH-1:0] rx_sr, rx_sr_n;
    logic [DATA_LENGTH-1:0] dout_n;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_n;
    logic [GAP_W-1:0]       gap_cnt, gap_cnt_n;
    logic                   sclk_n, mosi_n, ss_n, busy_n, done_n;
    logic                   div_en, rise_tick, fall_tick;

    // The divider runs only while SS is asserted. SETUP spends its first
    // cycle pulling SS low, so the first rise lands CLK_DIV cycles after SS
    // falls, and HOLD ends on the divider's next "rise" slot.
    assign div_en = !SS;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_comb begin
        state_n   = state;
        tx_sr_n   = tx_sr;
        rx_sr_n   = rx_sr;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        sclk_n    = SCLK;
        mosi_n    = MOSI;
        ss_n      = SS;
        busy_n    = busy;
        done_n    = 1'b0;
        dout_n    = data_from_slave;

        case (state)
            IDLE: begin
                if (start) begin
                    tx_sr_n   = data_to_slave;
                    bit_cnt_n = '0;
                    state_n   = SETUP;
                end
            end
            SETUP: begin
                if (SS) begin
                    ss_n   = 1'b0;
                    busy_n = 1'b1;
                    mosi_n = tx_sr[DATA_LENGTH-1];
                end else if (rise_tick) begin
                    sclk_n  = 1'b1;
                    rx_sr_n = {rx_sr[DATA_LENGTH-2:0], MISO};
                    state_n = XFER;
                end
            end
            XFER: begin
                if (rise_tick) begin
                    sclk_n  = 1'b1;
                    rx_sr_n = {rx_sr[DATA_LENGTH-2:0], MISO};
                end else if (fall_tick) begin
                    sclk_n = 1'b0;
                    if (bit_cnt == BIT_W'(DATA_LENGTH - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = HOLD;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_sr_n   = {tx_sr[DATA_LENGTH-2:0], 1'b0};
                        mosi_n    = tx_sr[DATA_LENGTH-2];
                    end
                end
            end
            HOLD: begin
                if (rise_tick) begin
                    ss_n      = 1'b1;
                    mosi_n    = 1'b0;
                    dout_n    = rx_sr;
                    done_n    = 1'b1;
                    gap_cnt_n = '0;
                    state_n   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            tx_sr           <= '0;
            rx_sr           <= '0;
            bit_cnt         <= '0;
            gap_cnt         <= '0;
            SCLK            <= 1'b0;
            MOSI            <= 1'b0;
            SS              <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            data_from_slave <= '0;
        end else begin
            state           <= state_n;
            tx_sr           <= tx_sr_n;
            rx_sr           <= rx_sr_n;
            bit_cnt         <= bit_cnt_n;
            gap_cnt         <= gap_cnt_n;
            SCLK            <= sclk_n;
            MOSI            <= mosi_n;
            SS              <= ss_n;
            busy            <= busy_n;
            done            <= done_n;
            data_from_slave <= dout_n;
        end
    end

endmodule

// File: tb/tb_m_spi_control.sv
// Self-checking bench for m_spi_control (DATA_LENGTH=8, CLK_DIV=4, GAP_CYCLES=4).
// A behavioural mode-0 slave shifts sl_tx out on MISO and collects MOSI;
// loop_en ties MISO to MOSI instead.
module tb_m_spi_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_to_slave = '0;
    logic [7:0] data_from_slave;
    logic       busy, done, SCLK, MOSI, MISO, SS;

    always #5 clk = ~clk;

    m_spi_control #(
        .DATA_LENGTH (8),
        .CLK_DIV     (4),
        .GAP_CYCLES  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .data_to_slave   (data_to_slave),
        .data_from_slave (data_from_slave),
        .busy            (busy),
        .done            (done),
        .SCLK            (SCLK),
        .MOSI            (MOSI),
        .MISO            (MISO),
        .SS              (SS)
    );

    // ---------------- behavioural slave ----------------
    logic       loop_en = 1'b0;
    logic [7:0] sl_tx = '0, sl_shift = '0, sl_rx = '0, sl_last_rx = '0;
    logic       sl_miso = 1'b0;
    logic       sl_prev_ss = 1'b1, sl_prev_sclk = 1'b0;
    int         rise_cnt = 0;

    assign MISO = loop_en ? MOSI : sl_miso;

    always @(SS or SCLK) begin
        if (sl_prev_ss !== 1'b0 && SS === 1'b0) begin
            sl_shift = sl_tx;
            sl_miso  = sl_tx[7];
        end else if (sl_prev_ss === 1'b0 && SS === 1'b1) begin
            sl_last_rx = sl_rx;
        end else if (SS === 1'b0 && sl_prev_sclk === 1'b1 && SCLK === 1'b0) begin
            sl_shift = {sl_shift[6:0], 1'b0};
            sl_miso  = sl_shift[7];
        end
        if (sl_prev_sclk === 1'b0 && SCLK === 1'b1) begin
            rise_cnt++;
            if (SS === 1'b0) sl_rx = {sl_rx[6:0], MOSI};
        end
        sl_prev_ss   = SS;
        sl_prev_sclk = SCLK;
    end

    // ---------------- cycle / pulse counters ----------------
    int cyc = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one transfer from IDLE and time its milestones relative to the
    // accepting edge; -1 means the milestone never showed up.
    task automatic run_xfer(input logic [7:0] d, output int t_ss, output int t_rise,
                            output int t_fall, output int t_done, output int t_busy);
        int   t0;
        logic prev;
        data_to_slave = d;
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        data_to_slave = ~d;
        t_ss = -1; t_rise = -1; t_fall = -1; t_done = -1; t_busy = -1;
        prev = SCLK;
        for (int i = 0; i < 200 && t_busy < 0; i++) begin
            tick();
            if (SS === 1'b0 && t_ss < 0) t_ss = cyc - t0;
            if (SCLK === 1'b1 && t_rise < 0) t_rise = cyc - t0;
            if (prev === 1'b1 && SCLK === 1'b0) t_fall = cyc - t0;
            if (done === 1'b1 && t_done < 0) t_done = cyc - t0;
            if (busy === 1'b0 && t_busy < 0) t_busy = cyc - t0;
            prev = SCLK;
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sl;
        logic       loop;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t       vecs[5];
    int         t_ss, t_rise, t_fall, t_done, t_busy;
    int         done0, rise0, t0, frames, run, min_gap;
    logic       in_gap;
    logic [7:0] held_exp[3];

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 1'b0, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 1'b0, 8'h00};
        vecs[3] = '{8'h81, 8'h7E, 1'b0, 8'h7E};
        vecs[4] = '{8'hC3, 8'h00, 1'b1, 8'hC3};
        held_exp[0] = 8'h00;
        held_exp[1] = 8'hFF;
        held_exp[2] = 8'h81;

        // ---- reset ----
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset SCLK", SCLK, 0);
        check("reset SS", SS, 1);
        check("reset MOSI", MOSI, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset data_from_slave", data_from_slave, 8'h00);

        // ---- table-driven single transfers ----
        for (int v = 0; v < 5; v++) begin
            loop_en = vecs[v].loop;
            sl_tx   = vecs[v].sl;
            done0   = done_cnt;
            run_xfer(vecs[v].tx, t_ss, t_rise, t_fall, t_done, t_busy);
            check($sformatf("v%0d SS low cycle", v), t_ss, 1);
            check($sformatf("v%0d first rise cycle", v), t_rise, 5);
            check($sformatf("v%0d last fall cycle", v), t_fall, 65);
            check($sformatf("v%0d done cycle", v), t_done, 69);
            check($sformatf("v%0d busy low cycle", v), t_busy, 73);
            check($sformatf("v%0d data_from_slave", v), data_from_slave, vecs[v].exp_rx);
            check($sformatf("v%0d MOSI bits at rises", v), sl_rx, vecs[v].tx);
            check($sformatf("v%0d done pulses", v), done_cnt - done0, 1);
            check($sformatf("v%0d SS idle", v), SS, 1);
            check($sformatf("v%0d MOSI idle", v), MOSI, 0);
        end

        // ---- loopback with start held high across three frames ----
        loop_en = 1'b1;
        data_to_slave = held_exp[0];
        start = 1'b1;
        frames = 0; in_gap = 1'b0; run = 0; min_gap = 1000;
        for (int i = 0; i < 1000 && frames < 3; i++) begin
            tick();
            if (done === 1'b1) begin
                check($sformatf("held frame %0d data_from_slave", frames), data_from_slave, held_exp[frames]);
                frames++;
                if (frames < 3) data_to_slave = held_exp[frames];
                else start = 1'b0;
                in_gap = 1'b1;
                run = 0;
            end
            if (in_gap) begin
                if (SS === 1'b1) run++;
                else begin
                    if (run < min_gap) min_gap = run;
                    in_gap = 1'b0;
                end
            end
        end
        check("held frames completed", frames, 3);
        check("held SS-high gap length", min_gap, 6);
        check("held gap at least GAP_CYCLES", min_gap >= 4, 1);
        for (int i = 0; i < 100 && busy !== 1'b0; i++) tick();
        check("held busy drops", busy, 0);

        // ---- start while busy is ignored ----
        loop_en = 1'b0;
        sl_tx = 8'h69;
        rise0 = rise_cnt;
        done0 = done_cnt;
        data_to_slave = 8'h96;
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        data_to_slave = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
        repeat (20) tick();
        check("ignored start SCLK rises", rise_cnt - rise0, 8);
        check("ignored start done pulses", done_cnt - done0, 1);
        check("ignored start data_from_slave", data_from_slave, 8'h69);
        check("ignored start slave received", sl_last_rx, 8'h96);
        check("ignored start busy idle", busy, 0);

        // ---- reset mid-transfer ----
        sl_tx = 8'hE7;
        data_to_slave = 8'hC6;
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("pre-abort SS", SS, 0);
        check("pre-abort SCLK", SCLK, 1);
        done0 = done_cnt;
        rst = 1'b1;
        tick();
        check("abort SS", SS, 1);
        check("abort SCLK", SCLK, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort data_from_slave", data_from_slave, 8'h00);
        rst = 1'b0;
        repeat (20) tick();
        check("abort no done pulse", done_cnt - done0, 0);
        sl_tx = 8'h96;
        run_xfer(8'h5A, t_ss, t_rise, t_fall, t_done, t_busy);
        check("after abort done cycle", t_done, 69);
        check("after abort data_from_slave", data_from_slave, 8'h96);
        check("after abort slave received", sl_last_rx, 8'h5A);

        // ---- master/slave exchange ----
        sl_tx = 8'hC3;
        run_xfer(8'h12, t_ss, t_rise, t_fall, t_done, t_busy);
        check("pair 1 slave received", sl_last_rx, 8'h12);
        check("pair 1 data_from_slave", data_from_slave, 8'hC3);
        run_xfer(8'h34, t_ss, t_rise, t_fall, t_done, t_busy);
        check("pair 2 slave received", sl_last_rx, 8'h34);
        check("pair 2 data_from_slave", data_from_slave, 8'hC3);
        check("pair 2 busy low cycle", t_busy, 73);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
